// File: rtl/unidade_controle_n.sv
// unidade_controle_n: control unit for the werewolf (lobisomem) game with N_JOG players.
// It runs night turns and day votes, and keeps the alive mask and the pending night kill.
// It decides the winner from the counts of alive wolves and alive citizens.
// Optional feature: define DISC_TIMEOUT_EN to limit the day discussion to T_DISC cycles.
module unidade_controle_n #(
  parameter int unsigned N_JOG  = 5,
  parameter int unsigned W      = $clog2(N_JOG),
  parameter int unsigned T_DISC = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             jogar,
  input  logic             passa,
  input  logic [N_JOG-1:0] lobos,
  input  logic             jogou,
  input  logic [W-1:0]     alvo_noite,
  input  logic             votou,
  input  logic [W-1:0]     alvo_voto,
  output logic [W-1:0]     jogador_atual,
  output logic [N_JOG-1:0] vivos,
  output logic             turno,
  output logic             vez_lobo,
  output logic             morte_valida,
  output logic [W-1:0]     morto,
  output logic             discussao,
  output logic             votacao,
  output logic             vitoria_lobo,
  output logic             vitoria_cidadao,
  output logic [4:0]       db_estado
);

  typedef enum logic [4:0] {
    StInicial       = 5'd0,
    StReseta        = 5'd1,
    StPrepara       = 5'd2,
    StArmazena      = 5'd3,
    StPrepNoite     = 5'd4,
    StChecaVivo     = 5'd5,
    StDelayNoite    = 5'd6,
    StTurnoNoite    = 5'd7,
    StProxJog       = 5'd8,
    StAvaliaNoite   = 5'd9,
    StChecaNoite    = 5'd10,
    StDiaDisc       = 5'd11,
    StDiaVoto       = 5'd12,
    StEliminaDia    = 5'd13,
    StChecaDia      = 5'd14,
    StLoboGanhou    = 5'd15,
    StCidadaoGanhou = 5'd16
  } state_e;

  localparam logic [W-1:0] Ultimo = W'(N_JOG - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     jog_q;
  logic [N_JOG-1:0] vivos_q;
  logic [N_JOG-1:0] lobos_q;
  logic [W-1:0]     morto_q;
  logic [W-1:0]     pend_q;
  logic             pend_v_q;
  logic [W-1:0]     voto_q;

  // An index may be wider than the player count. Indices past the last player read as 0.
  function automatic logic bit_at(input logic [N_JOG-1:0] mask, input logic [W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int unsigned i = 0; i < N_JOG; i++) begin
      if (idx == W'(i)) b = mask[i];
    end
    return b;
  endfunction

  function automatic logic in_range(input logic [W-1:0] idx);
    return 32'(idx) < N_JOG;
  endfunction

  function automatic logic [N_JOG-1:0] limpa(input logic [N_JOG-1:0] mask,
                                             input logic [W-1:0] idx);
    logic [N_JOG-1:0] m;
    m = mask;
    for (int unsigned i = 0; i < N_JOG; i++) begin
      if (idx == W'(i)) m[i] = 1'b0;
    end
    return m;
  endfunction

  function automatic int unsigned conta(input logic [N_JOG-1:0] mask);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < N_JOG; i++) begin
      n = n + {31'b0, mask[i]};
    end
    return n;
  endfunction

  logic        ultimo;
  logic        vivo_atual;
  logic        lobo_atual;
  logic        mata_noite;
  logic        mata_dia;
  logic        disc_fim;
  int unsigned n_lobos;
  int unsigned n_cid;

  // Decode the current player and evaluate the win test and the elimination test.
  always_comb begin
    ultimo     = (jog_q == Ultimo);
    vivo_atual = bit_at(vivos_q, jog_q);
    lobo_atual = bit_at(lobos_q, jog_q);
    n_lobos    = conta(vivos_q & lobos_q);
    n_cid      = conta(vivos_q & ~lobos_q);
    // A night kill must hit a live citizen. Otherwise it is dropped.
    mata_noite = pend_v_q && in_range(pend_q) && bit_at(vivos_q, pend_q)
                 && !bit_at(lobos_q, pend_q);
    mata_dia   = in_range(voto_q) && bit_at(vivos_q, voto_q);
  end

`ifdef DISC_TIMEOUT_EN
  localparam int unsigned CW = $clog2(T_DISC) + 1;
  logic [CW-1:0] cnt_q;

  // Count the cycles spent in discussion. Any other state holds the count at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q != StDiaDisc) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign disc_fim = passa || (cnt_q == CW'(T_DISC - 1));
`else
  assign disc_fim = passa;
`endif

  // Next-state logic. Any illegal code falls back to INICIAL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StInicial:     if (jogar) state_d = StReseta;
      StReseta:      state_d = StPrepara;
      StPrepara:     if (passa) state_d = StArmazena;
      StArmazena: begin
        if (lobos == '0)      state_d = StCidadaoGanhou;
        else if (lobos == '1) state_d = StLoboGanhou;
        else                  state_d = StPrepNoite;
      end
      StPrepNoite:   state_d = StChecaVivo;
      StChecaVivo: begin
        if (vivo_atual)  state_d = StDelayNoite;
        else if (ultimo) state_d = StAvaliaNoite;
        else             state_d = StProxJog;
      end
      StDelayNoite:  if (passa) state_d = StTurnoNoite;
      StTurnoNoite: begin
        if (passa && jogou) state_d = ultimo ? StAvaliaNoite : StProxJog;
      end
      StProxJog:     state_d = StChecaVivo;
      StAvaliaNoite: state_d = StChecaNoite;
      StChecaNoite: begin
        if (n_lobos == 0)          state_d = StCidadaoGanhou;
        else if (n_lobos >= n_cid) state_d = StLoboGanhou;
        else                       state_d = StDiaDisc;
      end
      StDiaDisc:     if (disc_fim) state_d = StDiaVoto;
      StDiaVoto:     if (passa && votou) state_d = StEliminaDia;
      StEliminaDia:  state_d = StChecaDia;
      StChecaDia: begin
        if (n_lobos == 0)          state_d = StCidadaoGanhou;
        else if (n_lobos >= n_cid) state_d = StLoboGanhou;
        else                       state_d = StPrepNoite;
      end
      StLoboGanhou, StCidadaoGanhou: if (jogar) state_d = StReseta;
      default:       state_d = StInicial;
    endcase
  end

  // Update the state register and the game datapath on each state's exit edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StInicial;
      jog_q    <= '0;
      vivos_q  <= '1;
      lobos_q  <= '0;
      morto_q  <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      voto_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StReseta: begin
          jog_q    <= '0;
          vivos_q  <= '1;
          lobos_q  <= '0;
          morto_q  <= '0;
          pend_q   <= '0;
          pend_v_q <= 1'b0;
          voto_q   <= '0;
        end
        StArmazena: begin
          lobos_q <= lobos;
          vivos_q <= '1;
        end
        StPrepNoite: begin
          jog_q    <= '0;
          pend_q   <= '0;
          pend_v_q <= 1'b0;
        end
        StTurnoNoite: begin
          // Only a live wolf's choice counts. A later wolf overwrites an earlier one.
          if (passa && jogou && lobo_atual && vivo_atual) begin
            pend_q   <= alvo_noite;
            pend_v_q <= 1'b1;
          end
        end
        StProxJog: jog_q <= jog_q + W'(1);
        StAvaliaNoite: begin
          if (mata_noite) begin
            vivos_q <= limpa(vivos_q, pend_q);
            morto_q <= pend_q;
          end
        end
        StDiaVoto: begin
          if (passa && votou) voto_q <= alvo_voto;
        end
        StEliminaDia: begin
          if (mata_dia) begin
            vivos_q <= limpa(vivos_q, voto_q);
            morto_q <= voto_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    jogador_atual   = jog_q;
    vivos           = vivos_q;
    morto           = morto_q;
    turno           = (state_q == StTurnoNoite);
    vez_lobo        = turno && lobo_atual;
    morte_valida    = ((state_q == StAvaliaNoite) && mata_noite)
                      || ((state_q == StEliminaDia) && mata_dia);
    discussao       = (state_q == StDiaDisc);
    votacao         = (state_q == StDiaVoto);
    vitoria_lobo    = (state_q == StLoboGanhou);
    vitoria_cidadao = (state_q == StCidadaoGanhou);
    db_estado       = (state_q <= StCidadaoGanhou) ? 5'(state_q) : 5'h1F;
  end

endmodule

// File: tb/tb_unidade_controle_n.sv
// Testbench for unidade_controle_n with N_JOG=5 and T_DISC=8.
// A vector table drives one full game. Task sequences cover multi-night games,
// reset, and the end of the discussion phase.
module tb_unidade_controle_n;

  localparam int unsigned TD = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       jogar = 1'b0;
  logic       passa = 1'b0;
  logic [4:0] lobos = 5'b0;
  logic       jogou = 1'b0;
  logic [2:0] alvo_noite = 3'd0;
  logic       votou = 1'b0;
  logic [2:0] alvo_voto = 3'd0;
  logic [2:0] jogador_atual;
  logic [4:0] vivos;
  logic       turno;
  logic       vez_lobo;
  logic       morte_valida;
  logic [2:0] morto;
  logic       discussao;
  logic       votacao;
  logic       vitoria_lobo;
  logic       vitoria_cidadao;
  logic [4:0] db_estado;

  int total = 0;
  int bad   = 0;

  logic [4:0] m_viv;
  logic [4:0] m_lob;
  logic [2:0] m_morto;

  unidade_controle_n #(
    .N_JOG (5),
    .T_DISC(TD)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .jogar          (jogar),
    .passa          (passa),
    .lobos          (lobos),
    .jogou          (jogou),
    .alvo_noite     (alvo_noite),
    .votou          (votou),
    .alvo_voto      (alvo_voto),
    .jogador_atual  (jogador_atual),
    .vivos          (vivos),
    .turno          (turno),
    .vez_lobo       (vez_lobo),
    .morte_valida   (morte_valida),
    .morto          (morto),
    .discussao      (discussao),
    .votacao        (votacao),
    .vitoria_lobo   (vitoria_lobo),
    .vitoria_cidadao(vitoria_cidadao),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       jg;
    logic       ps;
    logic       jo;
    logic [2:0] an;
    logic       vo;
    logic [2:0] av;
    logic [4:0] est;
    logic [4:0] viv;
    logic       mv;
    logic [2:0] mo;
    logic [2:0] ja;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input logic jg, input logic ps, input logic jo,
                              input logic [2:0] an, input logic vo, input logic [2:0] av,
                              input logic [4:0] est, input logic [4:0] viv, input logic mv,
                              input logic [2:0] mo, input logic [2:0] ja);
    vec_t v;
    v.jg = jg; v.ps = ps; v.jo = jo; v.an = an; v.vo = vo; v.av = av;
    v.est = est; v.viv = viv; v.mv = mv; v.mo = mo; v.ja = ja;
    return v;
  endfunction

  task automatic chk(input string nome, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nome, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic limpa_ent();
    jogar = 1'b0; passa = 1'b0; jogou = 1'b0; votou = 1'b0;
  endtask

  // Expected outcome of a CHECA_* state, computed from the model masks.
  function automatic logic [4:0] esperado(input logic [4:0] v, input logic [4:0] l,
                                          input logic [4:0] cont);
    int nl;
    int nc;
    nl = 0;
    nc = 0;
    for (int i = 0; i < 5; i++) begin
      if (v[i] && l[i]) nl++;
      if (v[i] && !l[i]) nc++;
    end
    if (nl == 0) return 5'd16;
    if (nl >= nc) return 5'd15;
    return cont;
  endfunction

  // Start a game from INICIAL or a win state.
  task automatic start_game(input logic [4:0] l);
    lobos = l;
    jogar = 1'b1; step(); limpa_ent();
    chk("start.reseta", db_estado, 5'd1);
    step(); chk("start.prepara", db_estado, 5'd2);
    passa = 1'b1; step(); limpa_ent();
    chk("start.armazena", db_estado, 5'd3);
    step();
    m_viv = 5'h1F; m_lob = l; m_morto = 3'd0;
    chk("start.saida", db_estado, (l == 5'h00) ? 5'd16 : (l == 5'h1F) ? 5'd15 : 5'd4);
    chk("start.vivos", vivos, 5'h1F);
  endtask

  // Run one night from PREP_NOITE. Wolves target tgt and citizens pick 4.
  // stop_at halts in TURNO_NOITE of that player.
  task automatic night(input logic [2:0] tgt, input int stop_at);
    logic       pv;
    logic [2:0] pend;
    logic       mv_exp;
    pv = 1'b0;
    pend = 3'd0;
    step(); chk("noite.checa", db_estado, 5'd5); chk("noite.jog0", 5'(jogador_atual), 5'd0);
    for (int j = 0; j < 5; j++) begin
      if (m_viv[j]) begin
        step(); chk("noite.delay", db_estado, 5'd6);
        passa = 1'b1; step(); limpa_ent();
        chk("noite.turno", db_estado, 5'd7);
        chk("noite.vez_lobo", 5'(vez_lobo), 5'(m_lob[j]));
        if (j == stop_at) return;
        passa = 1'b1; jogou = 1'b1; alvo_noite = m_lob[j] ? tgt : 3'd4;
        step(); limpa_ent();
        if (m_lob[j]) begin pend = tgt; pv = 1'b1; end
      end else begin
        step();
      end
      chk("noite.fim_jog", db_estado, (j == 4) ? 5'd9 : 5'd8);
      if (j < 4) begin
        step(); chk("noite.prox", db_estado, 5'd5);
        chk("noite.jog", 5'(jogador_atual), 5'(j + 1));
      end
    end
    mv_exp = pv && (pend < 3'd5) && m_viv[pend] && !m_lob[pend];
    chk("noite.morte_valida", 5'(morte_valida), 5'(mv_exp));
    if (mv_exp) begin m_viv[pend] = 1'b0; m_morto = pend; end
    step(); chk("noite.checa_noite", db_estado, 5'd10);
    chk("noite.vivos", vivos, m_viv); chk("noite.morto", 5'(morto), 5'(m_morto));
    chk("noite.mv_baixo", 5'(morte_valida), 5'd0);
    step(); chk("noite.saida", db_estado, esperado(m_viv, m_lob, 5'd11));
  endtask

  // Run one day from DIA_DISC with a vote for av.
  task automatic day(input logic [2:0] av);
    logic mv_exp;
    passa = 1'b1; step(); limpa_ent();
    chk("dia.voto", db_estado, 5'd12); chk("dia.votacao", 5'(votacao), 5'd1);
    passa = 1'b1; votou = 1'b1; alvo_voto = av; step(); limpa_ent();
    chk("dia.elimina", db_estado, 5'd13);
    mv_exp = (av < 3'd5) && m_viv[av];
    chk("dia.morte_valida", 5'(morte_valida), 5'(mv_exp));
    if (mv_exp) begin m_viv[av] = 1'b0; m_morto = av; end
    step(); chk("dia.checa", db_estado, 5'd14); chk("dia.vivos", vivos, m_viv);
    chk("dia.morto", 5'(morto), 5'(m_morto));
    step(); chk("dia.saida", db_estado, esperado(m_viv, m_lob, 5'd4));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Game 1: player 0 is the only wolf. It kills 3 and is then voted out.
    //                jg  ps  jo  an    vo  av    est     viv     mv  mo    ja
    tab.push_back(mk(1, 0, 0, 3'd0, 0, 3'd0, 5'd1,  5'h1F, 0, 3'd0, 3'd0));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd2,  5'h1F, 0, 3'd0, 3'd0));
    tab.push_back(mk(0, 1, 0, 3'd0, 0, 3'd0, 5'd3,  5'h1F, 0, 3'd0, 3'd0));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd4,  5'h1F, 0, 3'd0, 3'd0));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd5,  5'h1F, 0, 3'd0, 3'd0));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd6,  5'h1F, 0, 3'd0, 3'd0));
    tab.push_back(mk(0, 1, 0, 3'd0, 0, 3'd0, 5'd7,  5'h1F, 0, 3'd0, 3'd0));
    tab.push_back(mk(0, 1, 1, 3'd3, 0, 3'd0, 5'd8,  5'h1F, 0, 3'd0, 3'd0));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd5,  5'h1F, 0, 3'd0, 3'd1));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd6,  5'h1F, 0, 3'd0, 3'd1));
    tab.push_back(mk(0, 1, 0, 3'd0, 0, 3'd0, 5'd7,  5'h1F, 0, 3'd0, 3'd1));
    tab.push_back(mk(0, 1, 1, 3'd4, 0, 3'd0, 5'd8,  5'h1F, 0, 3'd0, 3'd1));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd5,  5'h1F, 0, 3'd0, 3'd2));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd6,  5'h1F, 0, 3'd0, 3'd2));
    tab.push_back(mk(0, 1, 0, 3'd0, 0, 3'd0, 5'd7,  5'h1F, 0, 3'd0, 3'd2));
    tab.push_back(mk(0, 1, 1, 3'd4, 0, 3'd0, 5'd8,  5'h1F, 0, 3'd0, 3'd2));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd5,  5'h1F, 0, 3'd0, 3'd3));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd6,  5'h1F, 0, 3'd0, 3'd3));
    tab.push_back(mk(0, 1, 0, 3'd0, 0, 3'd0, 5'd7,  5'h1F, 0, 3'd0, 3'd3));
    tab.push_back(mk(0, 1, 1, 3'd4, 0, 3'd0, 5'd8,  5'h1F, 0, 3'd0, 3'd3));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd5,  5'h1F, 0, 3'd0, 3'd4));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd6,  5'h1F, 0, 3'd0, 3'd4));
    tab.push_back(mk(0, 1, 0, 3'd0, 0, 3'd0, 5'd7,  5'h1F, 0, 3'd0, 3'd4));
    tab.push_back(mk(0, 1, 1, 3'd4, 0, 3'd0, 5'd9,  5'h1F, 1, 3'd0, 3'd4));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd10, 5'h17, 0, 3'd3, 3'd4));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd11, 5'h17, 0, 3'd3, 3'd4));
    tab.push_back(mk(0, 1, 0, 3'd0, 0, 3'd0, 5'd12, 5'h17, 0, 3'd3, 3'd4));
    tab.push_back(mk(0, 1, 0, 3'd0, 1, 3'd0, 5'd13, 5'h17, 1, 3'd3, 3'd4));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd14, 5'h16, 0, 3'd0, 3'd4));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd16, 5'h16, 0, 3'd0, 3'd4));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd16, 5'h16, 0, 3'd0, 3'd4));
    tab.push_back(mk(1, 0, 0, 3'd0, 0, 3'd0, 5'd1,  5'h16, 0, 3'd0, 3'd4));
    tab.push_back(mk(0, 0, 0, 3'd0, 0, 3'd0, 5'd2,  5'h1F, 0, 3'd0, 3'd0));

    // Reset state.
    lobos = 5'b00001;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset.estado", db_estado, 5'd0);
    chk("reset.vivos", vivos, 5'h1F);
    chk("reset.jog", 5'(jogador_atual), 5'd0);
    chk("reset.morto", 5'(morto), 5'd0);
    chk("reset.flags", {turno, discussao, votacao, vitoria_lobo, vitoria_cidadao}, 5'd0);

    foreach (tab[i]) begin
      jogar = tab[i].jg; passa = tab[i].ps; jogou = tab[i].jo; alvo_noite = tab[i].an;
      votou = tab[i].vo; alvo_voto = tab[i].av;
      step(); limpa_ent();
      chk($sformatf("vec%0d.estado", i), db_estado, tab[i].est);
      chk($sformatf("vec%0d.vivos", i), vivos, tab[i].viv);
      chk($sformatf("vec%0d.morte_valida", i), 5'(morte_valida), 5'(tab[i].mv));
      chk($sformatf("vec%0d.morto", i), 5'(morto), 5'(tab[i].mo));
      chk($sformatf("vec%0d.jog", i), 5'(jogador_atual), 5'(tab[i].ja));
      if (i == 29) chk("vec.vitoria_cidadao", 5'(vitoria_cidadao), 5'd1);
    end

    // Back to INICIAL.
    reset = 1'b1; #1;
    chk("reset2.estado", db_estado, 5'd0);
    step(); reset = 1'b0;

    // Game B: one wolf. Covers skip votes, a dead player skipped at night,
    // a dead target, and a wolf target. Citizens win nothing.
    start_game(5'b00001);
    night(3'd2, -1);
    jogar = 1'b1; step(); limpa_ent();
    chk("b.jogar_ignorado", db_estado, 5'd11);
    day(3'd7);
    night(3'd3, -1);
    day(3'd7);
    night(3'd2, -1);
    day(3'd7);
    night(3'd0, -1);
    day(3'd7);
    night(3'd1, -1);
    chk("b.vitoria_lobo", 5'(vitoria_lobo), 5'd1);
    chk("b.vivos_final", vivos, 5'b10001);

    // Game C: two wolves. One kill gives L == C and the wolves win.
    start_game(5'b00011);
    night(3'd2, -1);
    chk("c.estado", db_estado, 5'd15);

    // Degenerate role masks decided in ARMAZENA.
    start_game(5'b00000);
    chk("d.cidadao", 5'(vitoria_cidadao), 5'd1);
    start_game(5'b11111);
    chk("d.lobo", 5'(vitoria_lobo), 5'd1);

    // Reset during player 2's night turn on the second night.
    start_game(5'b00001);
    night(3'd3, -1);
    day(3'd7);
    night(3'd1, 2);
    chk("e.pre_jog", 5'(jogador_atual), 5'd2);
    chk("e.pre_vivos", vivos, 5'b10111);
    reset = 1'b1; #1;
    chk("e.estado", db_estado, 5'd0);
    chk("e.vivos", vivos, 5'h1F);
    chk("e.jog", 5'(jogador_atual), 5'd0);
    chk("e.morto", 5'(morto), 5'd0);
    step(); reset = 1'b0;
    chk("e.estado_ciclo", db_estado, 5'd0);

    // Discussion exit without passa.
    start_game(5'b00001);
    night(3'd3, -1);
`ifdef DISC_TIMEOUT_EN
    for (int k = 1; k < int'(TD); k++) begin
      step(); chk("f.disc_espera", db_estado, 5'd11);
    end
    step(); chk("f.timeout", db_estado, 5'd12);
`else
    repeat (20) begin
      step(); chk("f.disc_fica", db_estado, 5'd11);
    end
    chk("f.discussao", 5'(discussao), 5'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
